// File: rtl/dma_pkg.sv
// Shared DMA datapath constants and the writer control state encoding.
// Also used by the 64->256 packer so both sides agree on the packed word width.
package dma_pkg;
    localparam int DMA_DATA_W = 256;
    localparam int DMA_ADDR_W = 12;
    localparam int DMA_LEN_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/dma_hold_reg.sv
// One-entry data+address holding register that presents a write until it is taken.
// Output is registered (load to present = 1 cycle); refills in the commit cycle when rdy.
module dma_hold_reg
    import dma_pkg::*;
#(
    parameter int DW = DMA_DATA_W,
    parameter int AW = DMA_ADDR_W
) (
    input  logic          clk_h,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic [AW-1:0] i_addr,
    input  logic          i_stall,
    output logic          o_vld,
    output logic          o_rdy,
    output logic          o_commit,
    output logic [DW-1:0] o_data,
    output logic [AW-1:0] o_addr
);
    logic          r_vld;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_addr;

    assign o_vld    = r_vld;
    assign o_data   = r_data;
    assign o_addr   = r_addr;
    assign o_commit = r_vld && !i_stall;
    assign o_rdy    = !r_vld || !i_stall;

    always_ff @(posedge clk_h) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_addr <= '0;
        end else if (i_flush) begin
            r_vld  <= 1'b0;
        end else if (i_load) begin
            // a load in the commit cycle replaces the entry without a bubble
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_addr <= i_addr;
        end else if (o_commit) begin
            r_vld  <= 1'b0;
        end
    end
endmodule

// File: rtl/dma_mem_writer.sv
// Writes packed words from the packer to consecutive SRAM addresses and pulses done at the end.
// Word accepted in cycle N is written from N+1; SRAM stalls hold the write and drop in_ack.
module dma_mem_writer
    import dma_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              clk_h,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    output logic              busy,
    output logic              done
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr_ptr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_acc_cnt;
    logic [LEN_W-1:0]   r_wr_cnt;
    logic               w_xfer;
    logic               w_commit;
    logic               w_hold_rdy;
    logic               w_last_commit;

    assign w_xfer        = in_valid && in_ack;
    assign w_last_commit = w_commit && ((r_wr_cnt + LEN_W'(1)) == r_len);

    dma_hold_reg #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_hold (
        .clk_h    (clk_h),
        .rst      (rst),
        .i_flush  (abort),
        .i_load   (w_xfer),
        .i_data   (in_data),
        .i_addr   (r_addr_ptr),
        .i_stall  (mem_stall),
        .o_vld    (mem_we),
        .o_rdy    (w_hold_rdy),
        .o_commit (w_commit),
        .o_data   (mem_wdata),
        .o_addr   (mem_addr)
    );

    always_ff @(posedge clk_h) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (num_words == '0) ? DONE : RUN;
            RUN:     if (w_last_commit) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    always_comb begin
        in_ack = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            RUN: begin
                in_ack = (r_acc_cnt != r_len) && w_hold_rdy;
                busy   = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (rst) begin
            r_addr_ptr <= '0;
            r_len      <= '0;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
        end else if (abort) begin
            r_len      <= '0;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
        end else if (r_state == IDLE && start) begin
            r_addr_ptr <= base_addr;
            r_len      <= num_words;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
        end else begin
            // address pointer wraps naturally modulo 2^ADDR_W
            if (w_xfer) begin
                r_addr_ptr <= r_addr_ptr + ADDR_W'(1);
                r_acc_cnt  <= r_acc_cnt + LEN_W'(1);
            end
            if (w_commit) r_wr_cnt <= r_wr_cnt + LEN_W'(1);
        end
    end
endmodule

// File: tb/tb_dma_mem_writer.sv
// Directed self-checking bench for dma_mem_writer.
module tb_dma_mem_writer;
    logic         clk_h;
    logic         rst;
    logic         start;
    logic [11:0]  base_addr;
    logic [11:0]  num_words;
    logic         abort;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ack;
    logic         mem_we;
    logic [11:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_stall;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [11:0]  wa[$];
    logic [255:0] wd[$];
    int ack_cnt;
    int done_cnt;
    int nxt;
    int tag;

    dma_mem_writer dut (
        .clk_h     (clk_h),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_stall (mem_stall),
        .busy      (busy),
        .done      (done)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    function automatic logic [255:0] mk(input int t, input int k);
        logic [15:0] th;
        logic [15:0] kh;
        th = t[15:0];
        kh = k[15:0];
        return {8{th, kh}};
    endfunction

    // Records SRAM commits / handshakes for the current cycle, advances one clock,
    // and presents the packer's next word if the current one was taken.
    task automatic step();
        logic xfer;
        if (mem_we && !mem_stall) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        xfer = in_valid && in_ack;
        if (xfer) ack_cnt++;
        if (done) done_cnt++;
        @(posedge clk_h);
        #1;
        if (xfer) nxt++;
        in_data = mk(tag, nxt);
    endtask

    task automatic clear(input int t);
        wa.delete();
        wd.delete();
        ack_cnt  = 0;
        done_cnt = 0;
        nxt      = 0;
        tag      = t;
        in_data  = mk(tag, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 12'h000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if (mem_wdata !== 256'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (in_ack !== 1'b0) begin failures++; $display("FAIL reset_in_ack got=%b exp=0", in_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] ack_h, we_h, done_h, busy_h;
        clear(1);
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            start     = (c == 0);
            base_addr = 12'h010;
            num_words = 12'd4;
            #1;
            ack_h[c]  = in_ack;
            we_h[c]   = mem_we;
            done_h[c] = done;
            busy_h[c] = busy;
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++; if (ack_h !== 8'b0001_1110) begin failures++; $display("FAIL basic_ack got=%b exp=00011110", ack_h); end
        checks++; if (we_h !== 8'b0011_1100) begin failures++; $display("FAIL basic_we got=%b exp=00111100", we_h); end
        checks++; if (done_h !== 8'b0100_0000) begin failures++; $display("FAIL basic_done got=%b exp=01000000", done_h); end
        checks++; if (busy_h !== 8'b0111_1110) begin failures++; $display("FAIL basic_busy got=%b exp=01111110", busy_h); end
        checks++; if (wa.size() !== 4) begin failures++; $display("FAIL basic_nwrites got=%0d exp=4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 12'h010 + 12'(i)) begin failures++; $display("FAIL basic_addr%0d got=%h exp=%h", i, wa[i], 12'h010 + 12'(i)); end
            checks++; if (wd[i] !== mk(1, i)) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, wd[i], mk(1, i)); end
        end
    endtask

    task automatic test_stall();
        clear(2);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            start     = (c == 0);
            base_addr = 12'h020;
            num_words = 12'd3;
            mem_stall = (c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                checks++; if (mem_addr !== 12'h021 || mem_we !== 1'b1) begin failures++; $display("FAIL stall_addr c=%0d got=%h we=%b exp=021 we=1", c, mem_addr, mem_we); end
                checks++; if (mem_wdata !== mk(2, 1)) begin failures++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, mem_wdata, mk(2, 1)); end
                checks++; if (in_ack !== 1'b0) begin failures++; $display("FAIL stall_ack c=%0d got=%b exp=0", c, in_ack); end
            end
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        mem_stall = 1'b0;
        checks++; if (wa.size() !== 3) begin failures++; $display("FAIL stall_nwrites got=%0d exp=3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 12'h020 + 12'(i) || wd[i] !== mk(2, i)) begin failures++; $display("FAIL stall_write%0d got=%h/%h exp=%h/%h", i, wa[i], wd[i], 12'h020 + 12'(i), mk(2, i)); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_a[4];
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        clear(3);
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            start     = (c == 0);
            base_addr = 12'hFFE;
            num_words = 12'd4;
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++; if (wa.size() !== 4) begin failures++; $display("FAIL wrap_nwrites got=%0d exp=4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, wa[i], exp_a[i]); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_zero_len();
        logic [3:0] done_h;
        clear(4);
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            start     = (c == 0);
            base_addr = 12'h080;
            num_words = 12'd0;
            #1;
            done_h[c] = done;
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++; if (done_h !== 4'b0010) begin failures++; $display("FAIL zero_done got=%b exp=0010", done_h); end
        checks++; if (wa.size() !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wa.size()); end
        checks++; if (ack_cnt !== 0) begin failures++; $display("FAIL zero_ack got=%0d exp=0", ack_cnt); end
    endtask

    task automatic test_abort();
        clear(5);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            start     = (c == 0);
            base_addr = 12'h040;
            num_words = 12'd8;
            step();
        end
        start = 1'b0;
        checks++; if (ack_cnt !== 2) begin failures++; $display("FAIL abort_pre_ack got=%0d exp=2", ack_cnt); end
        in_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_we got=%b exp=0", mem_we); end
        clear(6);
        for (int c = 0; c < 3; c++) step();
        checks++; if (done_cnt !== 0 || wa.size() !== 0) begin failures++; $display("FAIL abort_quiet done=%0d writes=%0d exp=0/0", done_cnt, wa.size()); end
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            start     = (c == 0);
            base_addr = 12'h100;
            num_words = 12'd1;
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++; if (wa.size() !== 1) begin failures++; $display("FAIL abort_restart_n got=%0d exp=1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] !== 12'h100 || wd[0] !== mk(6, 0)) begin failures++; $display("FAIL abort_restart_w got=%h/%h exp=100/%h", wa[0], wd[0], mk(6, 0)); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL abort_restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_ignored();
        clear(7);
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ack !== 1'b0) begin failures++; $display("FAIL idle_ack c=%0d got=%b exp=0", c, in_ack); end
            step();
        end
        in_valid = 1'b0;
        start = 1'b1; base_addr = 12'h200; num_words = 12'd3;
        step();
        start = 1'b1; base_addr = 12'h300; num_words = 12'd5;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) step();
        in_valid = 1'b0;
        checks++; if (ack_cnt !== 3) begin failures++; $display("FAIL ign_ack got=%0d exp=3", ack_cnt); end
        checks++; if (wa.size() !== 3) begin failures++; $display("FAIL ign_nwrites got=%0d exp=3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 12'h200 + 12'(i)) begin failures++; $display("FAIL ign_addr%0d got=%h exp=%h", i, wa[i], 12'h200 + 12'(i)); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear(8);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            start     = (c == 0);
            base_addr = 12'h050;
            num_words = 12'd4;
            step();
        end
        start = 1'b0;
        rst = 1'b1;
        abort = 1'b1;
        step();
        rst = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 12'h000 || mem_wdata !== 256'h0) begin failures++; $display("FAIL rstmid_mem got=%b/%h/%h exp=0/000/0", mem_we, mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ack !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got=%b%b%b exp=000", busy, done, in_ack); end
        done_cnt = 0;
        for (int c = 0; c < 4; c++) step();
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_cnt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; mem_stall = 1'b0;
        tag = 0; nxt = 0; ack_cnt = 0; done_cnt = 0;
        @(posedge clk_h);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_len();
        test_abort();
        test_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
